// File: rtl/imem_resp_pkg.sv
// Shared types and constants for the instruction-store AXI read responder.
package imem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } imem_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/imem_resp_skid_fifo.sv
// Two-entry {data, last, resp} FIFO between the store read port and the AXI R channel.
module imem_resp_skid_fifo #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_last,
    input  logic [1:0]   in_resp,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    output logic         out_last,
    output logic [1:0]   out_resp
);
    import imem_resp_pkg::*;

    localparam int EW = W + 3;

    logic [EW-1:0] ent_q [2];
    logic [EW-1:0] ent_d [2];
    logic          wr_q, wr_d;
    logic          rd_q, rd_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          push, pop;

    assign in_ready  = (cnt_q != 2'(FIFO_DEPTH));
    assign out_valid = (cnt_q != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Head entry drives the outputs directly, so it holds steady while stalled.
    assign {out_data, out_last, out_resp} = ent_q[rd_q];

    always_comb begin
        ent_d = ent_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            ent_d[wr_q] = {in_data, in_last, in_resp};
            wr_d        = ~wr_q;
        end
        if (pop) begin
            rd_d = ~rd_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ent_q[0] <= '0;
            ent_q[1] <= '0;
            wr_q     <= 1'b0;
            rd_q     <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            ent_q <= ent_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/imem_axi_rd_responder.sv
// AXI4 INCR read responder backed by a preloadable word store.
// Optional IMEM_RESP_OOR_ERR_EN: out-of-range beats return SLVERR instead of wrapping.
module imem_axi_rd_responder #(
    parameter int AXI_ADDR_WIDTH  = 42,
    parameter int AXI_DATA_WIDTH  = 64,
    parameter int AXI_BURST_WIDTH = 8,
    parameter int MEM_DEPTH_LOG2  = 10,
    parameter logic [AXI_ADDR_WIDTH-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [AXI_ADDR_WIDTH-1:0]  s_araddr,
    input  logic [AXI_BURST_WIDTH-1:0] s_arlen,
    input  logic                       s_arvalid,
    output logic                       s_arready,
    output logic [AXI_DATA_WIDTH-1:0]  s_rdata,
    output logic [1:0]                 s_rresp,
    output logic                       s_rlast,
    output logic                       s_rvalid,
    input  logic                       s_rready,
    input  logic                       load_we,
    input  logic [MEM_DEPTH_LOG2-1:0]  load_addr,
    input  logic [AXI_DATA_WIDTH-1:0]  load_data,
    output logic                       busy,
    output logic                       err_sticky
);
    import imem_resp_pkg::*;

    localparam int BYTE_SHIFT = $clog2(AXI_DATA_WIDTH / 8);
    localparam int REM_W      = AXI_BURST_WIDTH + 1;
    localparam int DEPTH      = 1 << MEM_DEPTH_LOG2;

    logic [AXI_DATA_WIDTH-1:0] store_mem [DEPTH];

    imem_state_e               state_q, state_d;
    logic [AXI_ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                      below_q, below_d;
    logic [REM_W-1:0]          rem_q, rem_d;
    logic                      err_q, err_d;

    logic [AXI_ADDR_WIDTH:0]   ar_diff;
    logic [AXI_ADDR_WIDTH-1:0] ar_word;
    logic [AXI_DATA_WIDTH-1:0] rd_word;
    logic [AXI_DATA_WIDTH-1:0] push_data;
    logic [1:0]                push_resp;
    logic                      push_last;
    logic                      beat_oor;
    logic                      issue;
    logic                      fifo_in_ready;

    // The borrow bit of the widened subtraction flags addresses below BASE_ADDR.
    assign ar_diff = {1'b0, s_araddr} - {1'b0, BASE_ADDR};
    assign ar_word = ar_diff[AXI_ADDR_WIDTH-1:0] >> BYTE_SHIFT;

    assign rd_word   = store_mem[idx_q[MEM_DEPTH_LOG2-1:0]];
    assign push_last = (rem_q == REM_W'(1));

`ifdef IMEM_RESP_OOR_ERR_EN
    assign beat_oor   = below_q || ((idx_q >> MEM_DEPTH_LOG2) != '0);
    assign push_data  = beat_oor ? '0 : rd_word;
    assign push_resp  = beat_oor ? RESP_SLVERR : RESP_OKAY;
    assign err_sticky = err_q;
`else
    logic unused_oor;
    assign beat_oor   = 1'b0;
    assign push_data  = rd_word;
    assign push_resp  = RESP_OKAY;
    assign err_sticky = 1'b0;
    assign unused_oor = ^{below_q, err_q, idx_q[AXI_ADDR_WIDTH-1:MEM_DEPTH_LOG2]};
`endif

    // Both channels: a transfer happens on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and a presented beat stays unchanged until accepted.
    assign s_arready = (state_q == IDLE) && !reset;
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        below_d = below_q;
        rem_d   = rem_q;
        err_d   = err_q;
        issue   = 1'b0;
        case (state_q)
            IDLE: begin
                if (s_arvalid && s_arready) begin
                    idx_d   = ar_word;
                    below_d = ar_diff[AXI_ADDR_WIDTH];
                    rem_d   = {1'b0, s_arlen} + REM_W'(1);
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                // The FIFO entry is the store's read register, so a free slot is the issue credit.
                if (fifo_in_ready) begin
                    issue = 1'b1;
                    idx_d = idx_q + AXI_ADDR_WIDTH'(1);
                    rem_d = rem_q - REM_W'(1);
                    err_d = err_q | beat_oor;
                    if (push_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (s_rvalid && s_rready && s_rlast) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= '0;
            below_q <= 1'b0;
            rem_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            below_q <= below_d;
            rem_q   <= rem_d;
            err_q   <= err_d;
        end
    end

    // Store contents are deliberately kept across reset; reads see pre-write data.
    always_ff @(posedge clk) begin
        if (load_we) begin
            store_mem[load_addr] <= load_data;
        end
    end

    imem_resp_skid_fifo #(
        .W (AXI_DATA_WIDTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (issue),
        .in_ready  (fifo_in_ready),
        .in_data   (push_data),
        .in_last   (push_last),
        .in_resp   (push_resp),
        .out_valid (s_rvalid),
        .out_ready (s_rready),
        .out_data  (s_rdata),
        .out_last  (s_rlast),
        .out_resp  (s_rresp)
    );

endmodule
